// File: rtl/dht_sensor_ctrl.sv
// DHT11/DHT22 single-wire controller: start request, 40-bit frame capture, checksum
// verification, scaled outputs and an enforced minimum interval between reads.
module dht_sensor_ctrl #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned MIN_INTERVAL_MS = 2000,
  parameter int unsigned BIT1_US         = 40,
  parameter int unsigned TIMEOUT_US      = 200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dht_in,
  output logic        dht_oe,
  input  logic        mode,
  input  logic        start,
  input  logic        auto_en,
  output logic        busy,
  output logic        valid,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [39:0] raw,
  output logic [15:0] hum_x10,
  output logic [15:0] temp_x10
);
  localparam int unsigned TICK_DIV = (CLK_HZ < 2_000_000) ? 1 : CLK_HZ / 1_000_000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [31:0] REQ11_US = 32'd18000;
  localparam logic [31:0] REQ22_US = 32'd1100;
  localparam logic [31:0] REL_MIN  = 32'd20;
  localparam logic [31:0] TMO      = 32'(TIMEOUT_US);
  localparam logic [31:0] BIT1     = 32'(BIT1_US);
  localparam logic [31:0] COOL_US  = 32'(MIN_INTERVAL_MS * 1000);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_LOW, S_REL, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_COOLDOWN
  } state_t;

  state_t       state_q, state_d;
  logic [PW-1:0] presc_q;
  logic         tick;
  logic [1:0]   sync_q;
  logic         line;
  logic [31:0]  cnt_q;
  logic         mode_q, pending_q;
  logic [39:0]  frame_q;
  logic [5:0]   bit_idx_q;
  logic         ok_d, fail_d;
  logic [2:0]   fail_code_d;
  logic [31:0]  req_us;
  logic [7:0]   b0, b1, b2, b3, b4, sum_c;
  logic [15:0]  hum_c, temp_mag, temp_c;
  logic         temp_neg;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign line   = sync_q[1];
  assign req_us = mode_q ? REQ22_US : REQ11_US;
  assign {b0, b1, b2, b3, b4} = frame_q;
  assign sum_c  = b0 + b1 + b2 + b3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_COOLDOWN;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ok_d        = 1'b0;
    fail_d      = 1'b0;
    fail_code_d = 3'd0;
    unique case (state_q)
      S_IDLE:      if (start || pending_q || auto_en) state_d = S_REQ_LOW;
      S_REQ_LOW:   if (cnt_q >= req_us) state_d = S_REL;
      S_REL:
        if (cnt_q >= REL_MIN && !line) state_d = S_RESP_LOW;
        else if (cnt_q >= TMO) begin fail_d = 1'b1; fail_code_d = 3'd1; end
      S_RESP_LOW:
        if (line) state_d = S_RESP_HIGH;
        else if (cnt_q >= TMO) begin fail_d = 1'b1; fail_code_d = 3'd2; end
      S_RESP_HIGH:
        if (!line) state_d = S_BIT_LOW;
        else if (cnt_q >= TMO) begin fail_d = 1'b1; fail_code_d = 3'd3; end
      S_BIT_LOW:
        if (line) state_d = S_BIT_HIGH;
        else if (cnt_q >= TMO) begin fail_d = 1'b1; fail_code_d = 3'd4; end
      S_BIT_HIGH:
        if (!line) state_d = (bit_idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
        else if (cnt_q >= TMO) begin fail_d = 1'b1; fail_code_d = 3'd4; end
      S_CHECK: begin
        state_d = S_COOLDOWN;
        if (sum_c == b4) ok_d = 1'b1;
        else begin fail_d = 1'b1; fail_code_d = 3'd5; end
      end
      S_COOLDOWN:  if (cnt_q >= COOL_US) state_d = S_IDLE;
      default:     state_d = S_COOLDOWN;
    endcase
    if (fail_d) state_d = S_COOLDOWN;
  end

  always_comb begin
    dht_oe = (state_q == S_REQ_LOW);
    busy   = !(state_q inside {S_IDLE, S_COOLDOWN});
  end

  // Sensor encodings: DHT11 sends integer+decimal bytes, DHT22 sends sign-magnitude tenths.
  always_comb begin
    if (mode_q) begin
      hum_c    = {b0, b1};
      temp_mag = {1'b0, b2[6:0], b3};
      temp_neg = b2[7];
    end else begin
      hum_c    = 16'(b0) * 16'd10 + 16'(b1);
      temp_mag = 16'(b2) * 16'd10 + 16'(b3[6:0]);
      temp_neg = b3[7];
    end
    temp_c = temp_neg ? -temp_mag : temp_mag;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q   <= '0;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      pending_q <= 1'b0;
      frame_q   <= '0;
      bit_idx_q <= '0;
      valid     <= 1'b0;
      error     <= 1'b0;
      err_code  <= '0;
      raw       <= '0;
      hum_x10   <= '0;
      temp_x10  <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      sync_q  <= {sync_q[0], dht_in};
      // Phase counter restarts on every state change and saturates while parked.
      if (state_d != state_q)          cnt_q <= '0;
      else if (tick && cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
      valid <= ok_d;
      error <= fail_d;
      if (fail_d) err_code <= fail_code_d;
      if (ok_d) begin
        raw      <= frame_q;
        hum_x10  <= hum_c;
        temp_x10 <= temp_c;
      end
      if (state_q == S_IDLE) begin
        mode_q    <= mode;
        pending_q <= 1'b0;
      end else if (state_q == S_COOLDOWN && start) begin
        pending_q <= 1'b1;
      end
      if (state_q == S_RESP_HIGH) bit_idx_q <= '0;
      if (state_q == S_BIT_HIGH && !line) begin
        frame_q   <= {frame_q[38:0], (cnt_q > BIT1)};
        bit_idx_q <= bit_idx_q + 1'b1;
      end
    end
  end
endmodule
